// File: rtl/wir_ctrl_pkg.sv
// Shared WIR constants for the IEEE 1500 wrapper: register width, opcodes,
// capture pattern and the legal-opcode check.
package wrapper_pkg;

  localparam int WIR_W = 3;

  localparam logic [WIR_W-1:0] WS_BYPASS  = 3'd0;
  localparam logic [WIR_W-1:0] WS_EXTEST  = 3'd1;
  localparam logic [WIR_W-1:0] WP_EXTEST  = 3'd2;
  localparam logic [WIR_W-1:0] WS_PRELOAD = 3'd3;
  localparam logic [WIR_W-1:0] WS_INTEST  = 3'd4;

  // Loaded by CaptureWR so a shifted-out WIR always starts with a 1 on WSO.
  localparam logic [WIR_W-1:0] WIR_CAPTURE = 3'b001;

  function automatic logic is_legal(input logic [31:0] code);
    return code <= 32'(WS_INTEST);
  endfunction

endpackage

// File: rtl/wir_ctrl_if.sv
// Serial control/data bundle between the wrapper TAP-side controller and wir_ctrl.
// master drives the wrapper controls, slave (wir_ctrl) returns WSO and decode outputs.
interface wir_ctrl_if #(
  parameter int WIR_W = wrapper_pkg::WIR_W
);

  logic             WSI;
  logic             SelectWIR;
  logic             ShiftWR;
  logic             CaptureWR;
  logic             UpdateWR;
  logic             WPSE;
  logic             wbr_so;
  logic             WSO;
  logic             wse_outputs;
  logic             hold_outputs;
  logic             wpp_sel;
  logic [WIR_W-1:0] instr;
  logic             illegal;
  logic             wpp_done;

  modport master (
    output WSI, SelectWIR, ShiftWR, CaptureWR, UpdateWR, WPSE, wbr_so,
    input  WSO, wse_outputs, hold_outputs, wpp_sel, instr, illegal, wpp_done
  );

  modport slave (
    input  WSI, SelectWIR, ShiftWR, CaptureWR, UpdateWR, WPSE, wbr_so,
    output WSO, wse_outputs, hold_outputs, wpp_sel, instr, illegal, wpp_done
  );

endinterface

// File: rtl/wir_ctrl_wir_reg.sv
// WIR shift and update stages. Capture beats shift beats update; all controls
// are ignored unless the WIR path is selected.
module wir_reg
  import wrapper_pkg::*;
#(
  parameter int WIR_W = wrapper_pkg::WIR_W
) (
  input  logic             CLK,
  input  logic             resetn,
  input  logic             wsi_i,
  input  logic             sel_i,
  input  logic             shift_i,
  input  logic             capture_i,
  input  logic             update_i,
  output logic [WIR_W-1:0] shift_stage_o,
  output logic [WIR_W-1:0] update_stage_o
);

  localparam logic [WIR_W-1:0] CAPTURE_PAT = WIR_W'(WIR_CAPTURE);

  logic [WIR_W-1:0] shift_q;
  logic [WIR_W-1:0] shift_d;
  logic [WIR_W-1:0] update_q;
  logic [WIR_W-1:0] update_d;
  logic [WIR_W-1:0] shifted;

  // WSI enters at the MSB, the LSB moves out toward WSO.
  genvar gi;
  for (gi = 0; gi < WIR_W; gi++) begin : g_shift
    if (gi == WIR_W - 1) begin : g_msb
      assign shifted[gi] = wsi_i;
    end else begin : g_lower
      assign shifted[gi] = shift_q[gi+1];
    end
  end

  always_comb begin
    shift_d  = shift_q;
    update_d = update_q;
    if (sel_i) begin
      if (capture_i) begin
        shift_d = CAPTURE_PAT;
      end else if (shift_i) begin
        shift_d = shifted;
      end else if (update_i) begin
        update_d = shift_q;
      end
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      shift_q  <= '0;
      update_q <= '0;
    end else begin
      shift_q  <= shift_d;
      update_q <= update_d;
    end
  end

  assign shift_stage_o  = shift_q;
  assign update_stage_o = update_q;

endmodule

// File: rtl/wir_ctrl.sv
// IEEE 1500 WIR controller: instruction decode, WBY, WSO mux and WBR control.
// Optional WP_EXTEST shift-length limiter enabled by defining WPP_SHIFT_CNT_EN.
module wir_ctrl
  import wrapper_pkg::*;
#(
  parameter int WIR_W   = wrapper_pkg::WIR_W,
  parameter int WBR_LEN = 8
) (
  input logic       CLK,
  input logic       resetn,
  wir_ctrl_if.slave wr
);

  localparam logic [WIR_W-1:0] OP_BYPASS  = WIR_W'(WS_BYPASS);
  localparam logic [WIR_W-1:0] OP_EXTEST  = WIR_W'(WS_EXTEST);
  localparam logic [WIR_W-1:0] OP_WPP     = WIR_W'(WP_EXTEST);
  localparam logic [WIR_W-1:0] OP_PRELOAD = WIR_W'(WS_PRELOAD);
  localparam logic [WIR_W-1:0] OP_INTEST  = WIR_W'(WS_INTEST);

  if (WBR_LEN < 1) begin : g_len_chk
    $error("wir_ctrl: WBR_LEN must be at least 1");
  end

  logic [WIR_W-1:0] shift_stage;
  logic [WIR_W-1:0] update_stage;
  logic [WIR_W-1:0] active_op;
  logic             code_legal;
  logic             is_byp;
  logic             is_ext;
  logic             is_wpp;
  logic             is_pre;
  logic             is_int;
  logic             wse_wpp;
  logic             done_pulse;
  logic             wby_q;
  logic             wby_d;

  wir_reg #(
    .WIR_W (WIR_W)
  ) u_wir_reg (
    .CLK            (CLK),
    .resetn         (resetn),
    .wsi_i          (wr.WSI),
    .sel_i          (wr.SelectWIR),
    .shift_i        (wr.ShiftWR),
    .capture_i      (wr.CaptureWR),
    .update_i       (wr.UpdateWR),
    .shift_stage_o  (shift_stage),
    .update_stage_o (update_stage)
  );

  // Undefined codes behave exactly like WS_BYPASS.
  assign code_legal = is_legal(32'(update_stage));
  assign active_op  = code_legal ? update_stage : OP_BYPASS;

  assign is_byp = (active_op == OP_BYPASS);
  assign is_ext = (active_op == OP_EXTEST);
  assign is_wpp = (active_op == OP_WPP);
  assign is_pre = (active_op == OP_PRELOAD);
  assign is_int = (active_op == OP_INTEST);

  always_comb begin
    wby_d = wby_q;
    if (!wr.SelectWIR && is_byp) begin
      if (wr.CaptureWR) begin
        wby_d = 1'b0;
      end else if (wr.ShiftWR) begin
        wby_d = wr.WSI;
      end
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      wby_q <= 1'b0;
    end else begin
      wby_q <= wby_d;
    end
  end

`ifdef WPP_SHIFT_CNT_EN
  localparam int               CNT_W   = $clog2(WBR_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WBR_LEN);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             done_q;
  logic             done_d;
  logic             cnt_full;

  assign cnt_full = (cnt_q == CNT_MAX);

  // Counter saturates at WBR_LEN; done fires only on the transition into saturation.
  always_comb begin
    cnt_d = '0;
    if (is_wpp && wr.WPSE) begin
      cnt_d = cnt_full ? cnt_q : cnt_q + 1'b1;
    end
    done_d = (cnt_d == CNT_MAX) && !cnt_full;
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign wse_wpp    = wr.WPSE & ~cnt_full;
  assign done_pulse = done_q;
`else
  assign wse_wpp    = wr.WPSE;
  assign done_pulse = 1'b0;
`endif

  assign wr.hold_outputs = is_ext | is_wpp | is_int;
  assign wr.wse_outputs  = ((is_ext | is_pre | is_int) & wr.ShiftWR & ~wr.SelectWIR)
                         | (is_wpp & wse_wpp);
  assign wr.wpp_sel      = is_wpp;
  assign wr.instr        = update_stage;
  assign wr.illegal      = ~code_legal;
  assign wr.wpp_done     = done_pulse;

  assign wr.WSO = wr.SelectWIR ? shift_stage[0] : (is_byp ? wby_q : wr.wbr_so);

endmodule

// File: tb/tb_wir_ctrl.sv
// Directed self-checking bench for wir_ctrl: reset, WIR load/capture, bypass,
// PRELOAD/INTEST decode, WP_EXTEST run length, illegal code and reset mid-shift.
module tb_wir_ctrl;
  import wrapper_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  wir_ctrl_if #(.WIR_W(3)) bus ();

  wir_ctrl #(
    .WIR_W   (3),
    .WBR_LEN (8)
  ) dut (
    .CLK    (clk),
    .resetn (resetn),
    .wr     (bus.slave)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s got=%0h t=%0t", tag, got, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic load_wir(input logic [2:0] code);
    bus.SelectWIR = 1'b1;
    bus.ShiftWR   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.WSI = code[i];
      cyc();
    end
    bus.ShiftWR  = 1'b0;
    bus.UpdateWR = 1'b1;
    cyc();
    bus.UpdateWR  = 1'b0;
    bus.SelectWIR = 1'b0;
    bus.WSI       = 1'b0;
    #1;
  endtask

  initial begin
    int          n_wse;
    int          n_done;
    int          done_at;
    logic [2:0]  seq;
    logic        wsi_bit;

    // Reset with every control asserted
    resetn        = 1'b0;
    bus.WSI       = 1'b1;
    bus.SelectWIR = 1'b1;
    bus.ShiftWR   = 1'b1;
    bus.CaptureWR = 1'b1;
    bus.UpdateWR  = 1'b1;
    bus.WPSE      = 1'b1;
    bus.wbr_so    = 1'b1;
    #55;
    check_eq("rst_instr", 32'(bus.instr), 32'd0);
    check_eq("rst_wse", 32'(bus.wse_outputs), 32'd0);
    check_eq("rst_hold", 32'(bus.hold_outputs), 32'd0);
    check_eq("rst_wpp_sel", 32'(bus.wpp_sel), 32'd0);
    check_eq("rst_illegal", 32'(bus.illegal), 32'd0);
    check_eq("rst_wpp_done", 32'(bus.wpp_done), 32'd0);
    check_eq("rst_wso", 32'(bus.WSO), 32'd0);
    #3;
    bus.WSI       = 1'b0;
    bus.SelectWIR = 1'b0;
    bus.ShiftWR   = 1'b0;
    bus.CaptureWR = 1'b0;
    bus.UpdateWR  = 1'b0;
    bus.WPSE      = 1'b0;
    bus.wbr_so    = 1'b0;
    #2;
    resetn = 1'b1;
    cyc();

    // WIR load of WS_EXTEST
    load_wir(3'd1);
    check_eq("ext_instr", 32'(bus.instr), 32'd1);
    check_eq("ext_hold", 32'(bus.hold_outputs), 32'd1);
    check_eq("ext_wse_idle", 32'(bus.wse_outputs), 32'd0);
    bus.ShiftWR = 1'b1;
    #1;
    check_eq("ext_wse_shift", 32'(bus.wse_outputs), 32'd1);
    bus.wbr_so = 1'b1;
    #1;
    check_eq("ext_wso_wbr1", 32'(bus.WSO), 32'd1);
    bus.wbr_so = 1'b0;
    #1;
    check_eq("ext_wso_wbr0", 32'(bus.WSO), 32'd0);
    bus.ShiftWR = 1'b0;
    cyc();

    // Capture readout of the WIR
    bus.SelectWIR = 1'b1;
    bus.CaptureWR = 1'b1;
    cyc();
    bus.CaptureWR = 1'b0;
    bus.ShiftWR   = 1'b1;
    bus.WSI       = 1'b1;
    seq = 3'b001;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("cap_wso%0d", i), 32'(bus.WSO), 32'(seq[i]));
      cyc();
    end
    check_eq("cap_wso_wsi", 32'(bus.WSO), 32'd1);
    // Capture beats update: shift stage reloads 001, instr stays WS_EXTEST
    bus.ShiftWR   = 1'b0;
    bus.CaptureWR = 1'b1;
    bus.UpdateWR  = 1'b1;
    cyc();
    check_eq("prio_cap_instr", 32'(bus.instr), 32'd1);
    check_eq("prio_cap_wso", 32'(bus.WSO), 32'd1);
    // Shift beats update
    bus.CaptureWR = 1'b0;
    bus.ShiftWR   = 1'b1;
    bus.WSI       = 1'b0;
    cyc();
    check_eq("prio_shift_instr", 32'(bus.instr), 32'd1);
    check_eq("prio_shift_wso", 32'(bus.WSO), 32'd0);
    bus.ShiftWR = 1'b0;
    cyc();
    check_eq("upd_bypass_instr", 32'(bus.instr), 32'd0);
    bus.UpdateWR  = 1'b0;
    bus.SelectWIR = 1'b0;

    // Bypass: WSO is WSI delayed one clock
    bus.ShiftWR = 1'b1;
    #1;
    check_eq("byp_hold", 32'(bus.hold_outputs), 32'd0);
    check_eq("byp_wse", 32'(bus.wse_outputs), 32'd0);
    for (int i = 0; i < 6; i++) begin
      wsi_bit = (i % 2 == 0);
      bus.WSI = wsi_bit;
      cyc();
      check_eq($sformatf("byp_wso%0d", i), 32'(bus.WSO), 32'(wsi_bit));
    end
    bus.WSI = 1'b1;
    cyc();
    check_eq("byp_wso_pre_cap", 32'(bus.WSO), 32'd1);
    bus.CaptureWR = 1'b1;
    cyc();
    check_eq("byp_wso_cap", 32'(bus.WSO), 32'd0);
    bus.CaptureWR = 1'b0;
    bus.ShiftWR   = 1'b0;

    // WS_PRELOAD and WS_INTEST decode
    load_wir(3'd3);
    check_eq("pre_hold", 32'(bus.hold_outputs), 32'd0);
    bus.ShiftWR = 1'b1;
    #1;
    check_eq("pre_wse", 32'(bus.wse_outputs), 32'd1);
    bus.ShiftWR = 1'b0;
    load_wir(3'd4);
    check_eq("int_hold", 32'(bus.hold_outputs), 32'd1);
    check_eq("int_wpp_sel", 32'(bus.wpp_sel), 32'd0);

    // WP_EXTEST run length
    load_wir(3'd2);
    check_eq("wpp_sel", 32'(bus.wpp_sel), 32'd1);
    check_eq("wpp_hold", 32'(bus.hold_outputs), 32'd1);
    check_eq("wpp_wse_idle", 32'(bus.wse_outputs), 32'd0);
    n_wse   = 0;
    n_done  = 0;
    done_at = 99;
    bus.WPSE = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (bus.wse_outputs === 1'b1) n_wse++;
      if (bus.wpp_done === 1'b1) begin
        n_done++;
        done_at = i;
      end
      cyc();
    end
`ifdef WPP_SHIFT_CNT_EN
    check_eq("wpp_wse_cycles", 32'(n_wse), 32'd8);
    check_eq("wpp_done_count", 32'(n_done), 32'd1);
    check_eq("wpp_done_at", 32'(done_at), 32'd8);
`else
    check_eq("wpp_wse_cycles", 32'(n_wse), 32'd12);
    check_eq("wpp_done_count", 32'(n_done), 32'd0);
`endif
    bus.WPSE = 1'b0;
    cyc();
    bus.WPSE = 1'b1;
    #1;
    check_eq("wpp_wse_restart", 32'(bus.wse_outputs), 32'd1);
    bus.WPSE = 1'b0;
    cyc();

    // Illegal code 6 behaves as bypass
    load_wir(3'd6);
    check_eq("ill_flag", 32'(bus.illegal), 32'd1);
    check_eq("ill_hold", 32'(bus.hold_outputs), 32'd0);
    check_eq("ill_wpp_sel", 32'(bus.wpp_sel), 32'd0);
    bus.wbr_so  = 1'b1;
    bus.ShiftWR = 1'b1;
    bus.WSI     = 1'b0;
    cyc();
    check_eq("ill_wso_wby0", 32'(bus.WSO), 32'd0);
    bus.WSI = 1'b1;
    cyc();
    check_eq("ill_wso_wby1", 32'(bus.WSO), 32'd1);
    check_eq("ill_wse", 32'(bus.wse_outputs), 32'd0);
    bus.wbr_so = 1'b0;

    // Reset after two WIR shifts discards everything
    bus.SelectWIR = 1'b1;
    bus.WSI       = 1'b1;
    cyc();
    cyc();
    resetn = 1'b0;
    #1;
    check_eq("mid_rst_instr", 32'(bus.instr), 32'd0);
    check_eq("mid_rst_illegal", 32'(bus.illegal), 32'd0);
    check_eq("mid_rst_wso", 32'(bus.WSO), 32'd0);
    bus.ShiftWR = 1'b0;
    #3;
    resetn = 1'b1;
    bus.UpdateWR = 1'b1;
    cyc();
    check_eq("post_rst_upd_instr", 32'(bus.instr), 32'd0);
    check_eq("post_rst_upd_illegal", 32'(bus.illegal), 32'd0);
    bus.UpdateWR  = 1'b0;
    bus.SelectWIR = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
